rv32_cpu_regfile_sb: RTL

Second-generation integer register file for the rv32 CPU core. Features:
- parametrised width and depth (RVE)
- two write-back ports: single-cycle results and long-latency results (mem/div)
- up to three synchronous read ports with same-cycle write bypass
- per-register busy scoreboard for hazard detection
- zero-initialisation sweep after reset

Sits between the decode/issue stage and the execute/write-back stages of the core.

---
 rtl/rv32_cpu_regfile_sb.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rv32_cpu_regfile_sb.sv
// Integer register file with two write-back ports, bypassed synchronous reads,
// a busy scoreboard and a post-reset zeroing sweep. Optional parity: RF_PARITY_EN.
module rv32_cpu_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int RVE    = 0,
  parameter int RS3_EN = 1
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  output logic            o_ready,
  input  logic            i_wa_en,
  input  logic [4:0]      i_wa_addr,
  input  logic [XLEN-1:0] i_wa_data,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_iss_en,
  input  logic [4:0]      i_iss_rd,
`ifdef RF_PARITY_EN
  input  logic            i_par_inject,
`endif
  input  logic            i_rd_en,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  input  logic [4:0]      i_rs3_addr,
  output logic [XLEN-1:0] o_rs1,
  output logic [XLEN-1:0] o_rs2,
  output logic [XLEN-1:0] o_rs3,
  output logic            o_hazard,
  output logic [31:0]     o_busy,
  output logic [2:0]      o_par_err
);

  localparam int DEPTH = (RVE != 0) ? 16 : 32;
  localparam int AW    = (RVE != 0) ? 4 : 5;
  localparam logic [31:0] BUSY_MASK = (DEPTH == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_cnt;
  logic              w_run;
  logic [XLEN-1:0]   r_mem [DEPTH];
  logic [31:0]       r_busy;
  logic [31:0]       w_busy_nxt;
  logic              w_wa_act;
  logic              w_wb_act;
  logic              w_iss_act;
  logic              w_rs3_busy;
  logic [4:0]        w_rs_addr [3];
  logic [XLEN-1:0]   w_rd_data [3];
  logic [XLEN-1:0]   r_rs [3];
`ifdef RF_PARITY_EN
  logic              r_par [DEPTH];
  logic [2:0]        w_rd_perr;
  logic [2:0]        r_perr;
`endif

  // Writable/readable architectural address: x0 is hardwired, x16..x31 absent under RVE.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && !((RVE != 0) && a[4]);
  endfunction

  // Handshake: there is no backpressure. Write, issue and read inputs are honoured
  // only while o_ready=1; before that they are discarded without acknowledgement.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_cnt <= r_cnt + AW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_cnt == AW'(DEPTH - 1)) w_state_nxt = ST_RUN;
  end

  assign w_run     = (r_state == ST_RUN);
  assign o_ready   = w_run;
  assign w_wa_act  = w_run && i_wa_en  && addr_ok(i_wa_addr);
  assign w_wb_act  = w_run && i_wb_en  && addr_ok(i_wb_addr);
  assign w_iss_act = w_run && i_iss_en && addr_ok(i_iss_rd);

  // Port A is written last so it wins a same-address collision with port B.
  always_ff @(posedge i_clk) begin
    if (!w_run) begin
      r_mem[r_cnt] <= '0;
`ifdef RF_PARITY_EN
      r_par[r_cnt] <= 1'b0;
`endif
    end else begin
      if (w_wb_act) begin
        r_mem[i_wb_addr[AW-1:0]] <= i_wb_data;
`ifdef RF_PARITY_EN
        r_par[i_wb_addr[AW-1:0]] <= ^i_wb_data;
`endif
      end
      if (w_wa_act) begin
        r_mem[i_wa_addr[AW-1:0]] <= i_wa_data;
`ifdef RF_PARITY_EN
        r_par[i_wa_addr[AW-1:0]] <= (^i_wa_data) ^ i_par_inject;
`endif
      end
    end
  end

  // Issue is applied after completion so a same-cycle set/clear leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wb_act)  w_busy_nxt[i_wb_addr] = 1'b0;
    if (w_iss_act) w_busy_nxt[i_iss_rd]  = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_busy <= '0;
    else         r_busy <= w_busy_nxt;
  end

  assign o_busy     = r_busy & BUSY_MASK;
  assign w_rs3_busy = (RS3_EN != 0) && r_busy[i_rs3_addr];
  assign o_hazard   = w_run && ((i_rd_en && (r_busy[i_rs1_addr] || r_busy[i_rs2_addr] || w_rs3_busy))
                              || (i_iss_en && r_busy[i_iss_rd]));

  assign w_rs_addr[0] = i_rs1_addr;
  assign w_rs_addr[1] = i_rs2_addr;
  assign w_rs_addr[2] = i_rs3_addr;

  always_comb begin
    w_rd_data = '{default: '0};
`ifdef RF_PARITY_EN
    w_rd_perr = 3'b000;
`endif
    for (int p = 0; p < 3; p++) begin
      if (addr_ok(w_rs_addr[p]) && (p != 2 || RS3_EN != 0)) begin
        if (w_wa_act && i_wa_addr == w_rs_addr[p]) begin
          w_rd_data[p] = i_wa_data;
        end else if (w_wb_act && i_wb_addr == w_rs_addr[p]) begin
          w_rd_data[p] = i_wb_data;
        end else begin
          w_rd_data[p] = r_mem[w_rs_addr[p][AW-1:0]];
`ifdef RF_PARITY_EN
          w_rd_perr[p] = (^r_mem[w_rs_addr[p][AW-1:0]]) ^ r_par[w_rs_addr[p][AW-1:0]];
`endif
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int p = 0; p < 3; p++) r_rs[p] <= '0;
    end else if (w_run && i_rd_en) begin
      for (int p = 0; p < 3; p++) r_rs[p] <= w_rd_data[p];
    end
  end

  assign o_rs1 = r_rs[0];
  assign o_rs2 = r_rs[1];
  assign o_rs3 = r_rs[2];

`ifdef RF_PARITY_EN
  // Error is a one-cycle pulse tied to the capture that observed it.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                 r_perr <= 3'b000;
    else if (w_run && i_rd_en)   r_perr <= w_rd_perr;
    else                         r_perr <= 3'b000;
  end
  assign o_par_err = r_perr;
`else
  assign o_par_err = 3'b000;
`endif

endmodule
